display_scan_ctrl: RTL and testbench

- Parametrised multi-digit seven-segment controller for the calculator datapath; display values are no longer limited to 4 bits.
- Selects operand or result, converts it to decimal (sequential BCD) or hex digits, and time-multiplexes NUM_DIGITS common-anode digits.
- Debounces the display-mode button internally. Sits between the calculator FSM/ALU and the board display pins.

---
 rtl/display_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/display_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : display_pkg
// Brief   : Shared types, glyph constants and helpers for the display path.
// Revision: 1.0 - initial release
// ============================================================================
package display_pkg;

  typedef enum logic {MODE_DEC = 1'b0, MODE_HEX = 1'b1} mode_e;

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, LOAD = 2'd2} conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    seg_decode = SEG_BLANK;
    case (d)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      4'hF: seg_decode = 7'b0001110;
    endcase
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential double-dabble converter, one bit per cycle, VALUE_W steps.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int VALUE_W    = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      value_i,
  output logic                    done_o,
  output logic [NUM_DIGITS*4-1:0] bcd_o
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0]       bin_q;
  logic [BCD_W-1:0]         bcd_q;
  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W+VALUE_W-1:0] w_shift;
  logic [CNT_W-1:0]         cnt_q;
  logic                     active_q;

  always_comb begin
    w_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign w_shift = {w_adj, bin_q} << 1;
  // bcd_o already holds the post-step value so the caller can capture it on done_o
  assign bcd_o   = w_shift[BCD_W+VALUE_W-1:VALUE_W];
  assign done_o  = active_q && (cnt_q == CNT_W'(VALUE_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      bin_q    <= value_i;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      bin_q <= w_shift[VALUE_W-1:0];
      bcd_q <= bcd_o;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : display_scan_ctrl
// Brief   : Value select, BCD/hex conversion and multiplexed 7-seg scan.
//           Optional leading-zero blanking: DISPLAY_LEAD_ZERO_BLANK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int VALUE_W         = 8,
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_mode,
  input  logic                  confirmed_op1,
  input  logic                  confirmed_op2,
  input  logic [VALUE_W-1:0]    sw,
  input  logic [VALUE_W-1:0]    result,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  mode,
  output logic                  busy
);

  localparam int          BCD_W   = NUM_DIGITS * 4;
  localparam int          IDX_W   = $clog2(NUM_DIGITS);
  localparam int          REF_W   = $clog2(REFRESH_DIV + 1);
  localparam int          DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [63:0] MAX_DEC = pow10(NUM_DIGITS) - 64'd1;

  logic            btn_meta_q, btn_sync_q, btn_level_q;
  logic [DB_W-1:0] db_cnt_q;
  mode_e           mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      btn_level_q <= 1'b0;
      db_cnt_q    <= '0;
      mode_q      <= MODE_DEC;
    end else begin
      btn_meta_q <= btn_mode;
      btn_sync_q <= btn_meta_q;
      if (btn_sync_q == btn_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt_q    <= '0;
        btn_level_q <= btn_sync_q;
        if (btn_sync_q) mode_q <= (mode_q == MODE_DEC) ? MODE_HEX : MODE_DEC;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  logic [VALUE_W-1:0] sel_q;

  always_ff @(posedge clk) begin
    if (reset) sel_q <= '0;
    else       sel_q <= (!confirmed_op1 || !confirmed_op2) ? sw : result;
  end

  logic [BCD_W-1:0] w_hex;

  for (genvar b = 0; b < BCD_W; b++) begin : g_hex
    if (b < VALUE_W) begin : g_bit
      assign w_hex[b] = sel_q[b];
    end else begin : g_zero
      assign w_hex[b] = 1'b0;
    end
  end

  conv_state_e        state_q;
  logic [VALUE_W-1:0] last_val_q;
  mode_e              last_mode_q;
  logic [BCD_W-1:0]   stage_q, digits_q, w_bcd;
  logic               stage_dash_q, dash_q, busy_q;
  logic               w_change, w_ovf, w_start, w_done;

  assign w_change = (sel_q != last_val_q) || (mode_q != last_mode_q);
  assign w_ovf    = 64'(sel_q) > MAX_DEC;
  assign w_start  = (state_q == IDLE) && w_change && (mode_q == MODE_DEC) && !w_ovf;

  bin2bcd_seq #(
    .VALUE_W   (VALUE_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start_i(w_start),
    .value_i(sel_q),
    .done_o (w_done),
    .bcd_o  (w_bcd)
  );

  // Results are staged so the visible digits only ever change in LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_val_q   <= '0;
      last_mode_q  <= MODE_DEC;
      stage_q      <= '0;
      stage_dash_q <= 1'b0;
      digits_q     <= '0;
      dash_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_change) begin
            last_val_q  <= sel_q;
            last_mode_q <= mode_q;
            if (mode_q == MODE_HEX) begin
              stage_q      <= w_hex;
              stage_dash_q <= 1'b0;
              state_q      <= LOAD;
            end else if (w_ovf) begin
              stage_dash_q <= 1'b1;
              state_q      <= LOAD;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CONVERT;
            end
          end
        end
        CONVERT: begin
          if (w_done) begin
            stage_q      <= w_bcd;
            stage_dash_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          digits_q <= stage_q;
          dash_q   <= stage_dash_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [6:0] w_glyph [NUM_DIGITS];

  always_comb begin
`ifdef DISPLAY_LEAD_ZERO_BLANK_EN
    logic upper_zero;
    upper_zero = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_glyph[i] = seg_decode(digits_q[4*i +: 4]);
`ifdef DISPLAY_LEAD_ZERO_BLANK_EN
      upper_zero = upper_zero && (digits_q[4*i +: 4] == 4'd0);
      if (upper_zero && (i != 0)) w_glyph[i] = SEG_BLANK;
`endif
      if (dash_q) w_glyph[i] = SEG_DASH;
    end
  end

  logic [REF_W-1:0]      ref_cnt_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  w_wrap;

  assign w_wrap = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));

  always_comb begin
    idx_d = idx_q;
    if (w_wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // an and seg are both registered from idx_d so they switch on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
    end else begin
      ref_cnt_q <= w_wrap ? '0 : ref_cnt_q + 1'b1;
      idx_q     <= idx_d;
      an_q      <= ~(NUM_DIGITS'(1) << idx_d);
      seg_q     <= w_glyph[idx_d];
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign mode = (mode_q == MODE_HEX);
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_scan_ctrl
// Brief   : Self-checking bench for display_scan_ctrl (4-digit and 2-digit builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn_mode, op1, op2;
  logic [7:0] sw, result;
  logic [6:0] seg4, seg2;
  logic [3:0] an4;
  logic [1:0] an2;
  logic       mode4, mode2, busy4, busy2;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] cap4 [4];
  logic [6:0] cap2 [2];
  bit         mode_exp = 1'b0;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .VALUE_W(8), .NUM_DIGITS(4), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(3)
  ) dut4 (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .confirmed_op1(op1),
    .confirmed_op2(op2), .sw(sw), .result(result), .seg(seg4), .an(an4),
    .mode(mode4), .busy(busy4)
  );

  display_scan_ctrl #(
    .VALUE_W(8), .NUM_DIGITS(2), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(3)
  ) dut2 (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .confirmed_op1(op1),
    .confirmed_op2(op2), .sw(sw), .result(result), .seg(seg2), .an(an2),
    .mode(mode2), .busy(busy2)
  );

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
     12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
     15: return 7'b0001110;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected glyph at digit position pos of an n-digit display showing val
  function automatic logic [6:0] model_seg(input int n, input int pos, input int val, input bit hex);
    int p10, maxv, d, upper;
    p10 = 1;
    for (int k = 0; k < pos; k++) p10 = p10 * 10;
    maxv = 1;
    for (int k = 0; k < n; k++) maxv = maxv * 10;
    maxv = maxv - 1;
    if (!hex && val > maxv) return 7'b0111111;
    if (hex) begin
      upper = val >> (4 * pos);
      d     = upper % 16;
    end else begin
      upper = val / p10;
      d     = upper % 10;
    end
`ifdef DISPLAY_LEAD_ZERO_BLANK_EN
    if (pos != 0 && upper == 0) return 7'h7F;
`endif
    return glyph(d);
  endfunction

  function automatic logic [6:0] any_of(input int pos, input logic [6:0] s);
    if (s === model_seg(4, pos, 0, 1'b0) || s === model_seg(4, pos, 5, 1'b0) ||
        s === model_seg(4, pos, 99, 1'b0)) return 7'd1;
    return 7'd0;
  endfunction

  task automatic capture();
    logic [3:0] m4;
    logic [1:0] m2;
    for (int i = 0; i < 4; i++) cap4[i] = 'x;
    for (int i = 0; i < 2; i++) cap2[i] = 'x;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        m4 = 4'b1 << i;
        if (an4 == ~m4) cap4[i] = seg4;
      end
      for (int i = 0; i < 2; i++) begin
        m2 = 2'b1 << i;
        if (an2 == ~m2) cap2[i] = seg2;
      end
    end
  endtask

  task automatic press_button();
    btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    btn_mode = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] prev, exp_next;
    int run, runs;
    reset = 1'b1; btn_mode = 1'b0; op1 = 1'b0; op2 = 1'b0; sw = 8'd0; result = 8'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (an4 !== 4'b1111) begin n_bad++; $display("FAIL reset_an4: got %b want 1111", an4); end
    n_cmp++; if (seg4 !== 7'h7F) begin n_bad++; $display("FAIL reset_seg4: got %b want 1111111", seg4); end
    n_cmp++; if (mode4 !== 1'b0) begin n_bad++; $display("FAIL reset_mode: got %b want 0", mode4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy4); end
    n_cmp++; if (an2 !== 2'b11 || seg2 !== 7'h7F) begin n_bad++; $display("FAIL reset_dut2: got an=%b seg=%b", an2, seg2); end
    reset = 1'b0;
    prev = 4'b1111; run = 0; runs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an4 == prev) run++;
      else begin
        if (prev == 4'b1111) begin
          n_cmp++; if (an4 !== 4'b1110) begin n_bad++; $display("FAIL scan_first: got %b want 1110", an4); end
        end else begin
          exp_next = {prev[2:0], prev[3]};
          n_cmp++; if (an4 !== exp_next) begin n_bad++; $display("FAIL scan_order: got %b want %b", an4, exp_next); end
          if (runs >= 1) begin
            n_cmp++; if (run !== 4) begin n_bad++; $display("FAIL scan_dwell: got %0d want 4", run); end
          end
          runs++;
        end
        prev = an4; run = 1;
      end
    end
    n_cmp++; if (runs < 5) begin n_bad++; $display("FAIL scan_progress: got %0d runs want >=5", runs); end
  endtask

  task automatic test_decimal();
    int b4, b2;
    logic [6:0] e;
    b4 = 0; b2 = 0;
    op1 = 1'b1; op2 = 1'b1; result = 8'd173;
    repeat (20) begin
      @(negedge clk);
      if (busy4) b4++;
      if (busy2) b2++;
    end
    n_cmp++; if (b4 !== 8) begin n_bad++; $display("FAIL busy_len_173: got %0d want 8", b4); end
    n_cmp++; if (b2 !== 0) begin n_bad++; $display("FAIL busy_ovf_173: got %0d want 0", b2); end
    capture();
    for (int p = 0; p < 4; p++) begin
      e = model_seg(4, p, 173, 1'b0);
      n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL dec173_d%0d: got %b want %b", p, cap4[p], e); end
    end
    for (int p = 0; p < 2; p++) begin
      e = model_seg(2, p, 173, 1'b0);
      n_cmp++; if (cap2[p] !== e) begin n_bad++; $display("FAIL dec173_n2_d%0d: got %b want %b", p, cap2[p], e); end
    end
    n_cmp++; if (cap4[0] !== 7'b0110000) begin n_bad++; $display("FAIL dec173_units: got %b want 0110000", cap4[0]); end
  endtask

  task automatic test_mode_button();
    logic [6:0] e;
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (mode4 !== 1'b0 || mode2 !== 1'b0) begin n_bad++; $display("FAIL short_press: got %b%b want 00", mode4, mode2); end
    press_button();
    n_cmp++; if (mode4 !== 1'b1 || mode2 !== 1'b1) begin n_bad++; $display("FAIL long_press: got %b%b want 11", mode4, mode2); end
    repeat (4) @(negedge clk);
    capture();
    for (int p = 0; p < 4; p++) begin
      e = model_seg(4, p, 173, 1'b1);
      n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL hex173_d%0d: got %b want %b", p, cap4[p], e); end
    end
    for (int p = 0; p < 2; p++) begin
      e = model_seg(2, p, 173, 1'b1);
      n_cmp++; if (cap2[p] !== e) begin n_bad++; $display("FAIL hex173_n2_d%0d: got %b want %b", p, cap2[p], e); end
    end
    n_cmp++; if (cap4[0] !== 7'b0100001) begin n_bad++; $display("FAIL hex173_units: got %b want 0100001", cap4[0]); end
    press_button();
    n_cmp++; if (mode4 !== 1'b0) begin n_bad++; $display("FAIL repress: got %b want 0", mode4); end
    mode_exp = 1'b0;
  endtask

  task automatic test_overflow();
    int b2;
    logic [6:0] e;
    b2 = 0;
    op1 = 1'b1; op2 = 1'b1; result = 8'd200;
    repeat (20) begin
      @(negedge clk);
      if (busy2) b2++;
    end
    n_cmp++; if (b2 !== 0) begin n_bad++; $display("FAIL ovf_busy: got %0d want 0", b2); end
    capture();
    for (int p = 0; p < 2; p++) begin
      n_cmp++; if (cap2[p] !== 7'b0111111) begin n_bad++; $display("FAIL ovf_dash_d%0d: got %b want 0111111", p, cap2[p]); end
    end
    for (int p = 0; p < 4; p++) begin
      e = model_seg(4, p, 200, 1'b0);
      n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL dec200_d%0d: got %b want %b", p, cap4[p], e); end
    end
    op1 = 1'b0; sw = 8'd99;
    repeat (20) @(negedge clk);
    capture();
    for (int p = 0; p < 2; p++) begin
      n_cmp++; if (cap2[p] !== 7'b0010000) begin n_bad++; $display("FAIL sw99_n2_d%0d: got %b want 0010000", p, cap2[p]); end
    end
    for (int p = 0; p < 4; p++) begin
      e = model_seg(4, p, 99, 1'b0);
      n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL sw99_d%0d: got %b want %b", p, cap4[p], e); end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cyc, rises, first_run;
    bit prev_b, changed;
    logic [3:0] m4;
    logic [6:0] e;
    busy_cyc = 0; rises = 0; first_run = 0; prev_b = 1'b0; changed = 1'b0;
    reset = 1'b1; op1 = 1'b0; sw = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    sw = 8'd5;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy4 && !prev_b) rises++;
      if (busy4) begin
        busy_cyc++;
        if (rises == 1) first_run++;
      end
      if (busy4 && rises == 1 && first_run == 3 && !changed) begin
        sw = 8'd99;
        changed = 1'b1;
      end
      prev_b = busy4;
      for (int p = 0; p < 4; p++) begin
        m4 = 4'b1 << p;
        if (an4 == ~m4) begin
          n_cmp++; if (any_of(p, seg4) != 7'd1) begin n_bad++; $display("FAIL b2b_garbage_d%0d: got %b", p, seg4); end
        end
      end
    end
    n_cmp++; if (first_run !== 8) begin n_bad++; $display("FAIL b2b_first_busy: got %0d want 8", first_run); end
    n_cmp++; if (rises !== 2) begin n_bad++; $display("FAIL b2b_conversions: got %0d want 2", rises); end
    n_cmp++; if (busy_cyc !== 16) begin n_bad++; $display("FAIL b2b_busy_total: got %0d want 16", busy_cyc); end
    capture();
    for (int p = 0; p < 4; p++) begin
      e = model_seg(4, p, 99, 1'b0);
      n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL b2b_final_d%0d: got %b want %b", p, cap4[p], e); end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [6:0] e;
    w = 0;
    op1 = 1'b1; op2 = 1'b1; result = 8'd250;
    while (!busy4 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL mid_busy_start: got %b want 1", busy4); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy4); end
    n_cmp++; if (seg4 !== 7'h7F || an4 !== 4'b1111) begin n_bad++; $display("FAIL mid_reset_blank: got seg=%b an=%b want 1111111/1111", seg4, an4); end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    capture();
    for (int p = 0; p < 4; p++) begin
      e = model_seg(4, p, 250, 1'b0);
      n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL after_reset_d%0d: got %b want %b", p, cap4[p], e); end
    end
  endtask

  task automatic test_small_value();
    logic [6:0] e;
    op1 = 1'b0; sw = 8'd7;
    repeat (20) @(negedge clk);
    capture();
    for (int p = 0; p < 4; p++) begin
      e = model_seg(4, p, 7, 1'b0);
      n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL seven_d%0d: got %b want %b", p, cap4[p], e); end
    end
    n_cmp++; if (cap4[0] !== 7'b1111000) begin n_bad++; $display("FAIL seven_units: got %b want 1111000", cap4[0]); end
`ifdef DISPLAY_LEAD_ZERO_BLANK_EN
    n_cmp++; if (cap4[3] !== 7'h7F) begin n_bad++; $display("FAIL seven_blank_top: got %b want 1111111", cap4[3]); end
`endif
  endtask

  task automatic test_random();
    int v;
    logic [6:0] e;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        press_button();
        mode_exp = ~mode_exp;
      end
      sw     = 8'($urandom);
      result = 8'($urandom);
      op1    = 1'($urandom_range(0, 1));
      op2    = 1'($urandom_range(0, 1));
      repeat (30) @(negedge clk);
      v = (!op1 || !op2) ? int'(sw) : int'(result);
      n_cmp++; if (mode4 !== mode_exp) begin n_bad++; $display("FAIL rnd%0d_mode: got %b want %b", it, mode4, mode_exp); end
      capture();
      for (int p = 0; p < 4; p++) begin
        e = model_seg(4, p, v, mode_exp);
        n_cmp++; if (cap4[p] !== e) begin n_bad++; $display("FAIL rnd%0d_v%0d_d%0d: got %b want %b", it, v, p, cap4[p], e); end
      end
      for (int p = 0; p < 2; p++) begin
        e = model_seg(2, p, v, mode_exp);
        n_cmp++; if (cap2[p] !== e) begin n_bad++; $display("FAIL rnd%0d_n2_v%0d_d%0d: got %b want %b", it, v, p, cap2[p], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_mode_button();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_small_value();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
